// File: rtl/rm_hdr_chk_pkg.sv
// -----------------------------------------------------------------------------
// rm_hdr_chk_pkg
// Shared definitions for the receive-side header checker:
//   - IOQ header field positions inside a header data word
//   - parse state encoding
//   - word classification from the ctrl lanes
//   - byte count carried by the last (EOP) word of a packet
//   - 16/32-bit saturating arithmetic helpers
// Ctrl vectors are handled zero-extended to CTRL_MAX_W bits so the helpers
// serve any stream width up to CTRL_MAX_W byte lanes.
// -----------------------------------------------------------------------------
package rm_hdr_chk_pkg;

  // IOQ header layout: three 16-bit fields in the low 48 bits of the word.
  localparam int unsigned FIELD_W      = 16;
  localparam int unsigned BYTE_LEN_LSB = 0;
  localparam int unsigned SRC_PORT_LSB = 16;
  localparam int unsigned WORD_LEN_LSB = 32;

  // Widest ctrl vector the helper functions accept.
  localparam int unsigned CTRL_MAX_W = 32;

  // Entries held between parser and output port.
  localparam int unsigned BUF_DEPTH = 2;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    WK_DATA = 2'd0,
    WK_EOP  = 2'd1,
    WK_HDR  = 2'd2
  } word_kind_e;

  // No ctrl bit -> data, exactly one -> EOP, two or more -> module header.
  function automatic word_kind_e classify_word(input logic [CTRL_MAX_W-1:0] ctrl);
    logic [5:0] ones;
    ones = 6'($countones(ctrl));
    if (ones == 6'd0) begin
      return WK_DATA;
    end else if (ones == 6'd1) begin
      return WK_EOP;
    end else begin
      return WK_HDR;
    end
  endfunction

  // Valid bytes in an EOP word: the set lane bit i leaves (lanes - i) bytes,
  // so the lowest lane marks a full word and the top lane a single byte.
  function automatic logic [FIELD_W-1:0] last_word_bytes(
    input logic [CTRL_MAX_W-1:0] ctrl,
    input int unsigned           lanes
  );
    logic [FIELD_W-1:0] nbytes;
    nbytes = '0;
    for (int unsigned i = 0; i < CTRL_MAX_W; i++) begin
      nbytes = ctrl[i] ? 16'(lanes - i) : nbytes;
    end
    return nbytes;
  endfunction

  function automatic logic [FIELD_W-1:0] sat_add16(
    input logic [FIELD_W-1:0] a,
    input logic [FIELD_W-1:0] b
  );
    logic [FIELD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[FIELD_W] ? 16'hffff : sum[FIELD_W-1:0];
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] a);
    return (a == 32'hffff_ffff) ? a : a + 32'd1;
  endfunction

endpackage

// File: rtl/rm_hdr_chk_pkt_skid_buf.sv
// -----------------------------------------------------------------------------
// pkt_skid_buf
// Two-entry FIFO holding {ctrl,data} words between the parser and the output
// port. The head entry is always visible on head_o; a pop and a push in the
// same cycle are accepted even when both entries are occupied.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   push_i        write push_data_i (ignored when full and not popping)
//   push_data_i   word to store
//   pop_i         drop the head entry (ignored when empty)
//   head_o        oldest stored word
//   count_o       number of stored entries (0..2)
// -----------------------------------------------------------------------------
module pkt_skid_buf
  import rm_hdr_chk_pkg::*;
#(
  parameter int unsigned W = 72
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  logic [W-1:0] mem_q [BUF_DEPTH];
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  logic         do_pop_s;
  logic         do_push_s;
  logic         wr_ptr_s;

  // Qualify push/pop against occupancy and pick the write slot.
  always_comb begin
    do_pop_s  = pop_i && (count_q != 2'd0);
    do_push_s = push_i && ((count_q != FULL_CNT) || do_pop_s);
    // With two entries the free slot is the head being popped this cycle.
    wr_ptr_s  = rd_ptr_q ^ count_q[0];
  end

  // Storage, read pointer and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_s] <= push_data_i;
      end
      if (do_pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rm_hdr_chk.sv
// -----------------------------------------------------------------------------
// rm_hdr_chk
// Receive-side header checker. Strips the module-header words that lead each
// packet, forwards the payload (first data/EOP word through EOP), and checks
// the payload against the IOQ header (ctrl == STAGE_NUMBER): word length,
// byte length and source port.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_data/in_ctrl     input word; in_wr qualifies it, legal only with in_rdy
//   in_rdy              registered: buffer holds at most one entry
//   out_data/out_ctrl   head of the output buffer
//   out_wr              word transferred (out_rdy and buffer non-empty)
//   out_rdy             downstream can accept
//   len_err             one-cycle pulse after EOP: word/byte count mismatch
//   hdr_err             one-cycle pulse after EOP: no IOQ header or bad port
// Optional build macro RM_HDR_CHK_STATS_EN adds saturating counters
//   pkt_cnt (EOP words forwarded) and err_cnt (packets that raised an error).
// -----------------------------------------------------------------------------
module rm_hdr_chk
  import rm_hdr_chk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned CTRL_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned STAGE_NUMBER = 32'hff,
  parameter int unsigned PORT_NUMBER  = 32'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  len_err,
  output logic                  hdr_err
`ifdef RM_HDR_CHK_STATS_EN
 ,output logic [31:0]           pkt_cnt,
  output logic [31:0]           err_cnt
`endif
);

  localparam int unsigned        BUF_W      = DATA_WIDTH + CTRL_WIDTH;
  localparam logic [CTRL_WIDTH-1:0] STAGE_CTRL = CTRL_WIDTH'(STAGE_NUMBER);
  localparam logic [FIELD_W-1:0] PORT_EXP   = 16'(PORT_NUMBER);
  localparam logic [FIELD_W-1:0] LANE_BYTES = 16'(CTRL_WIDTH);

  // Parse state and counters.
  state_e             state_q,    state_d;
  logic [FIELD_W-1:0] wcnt_q,     wcnt_d;
  logic [FIELD_W-1:0] bcnt_q,     bcnt_d;
  logic [FIELD_W-1:0] byte_len_q, byte_len_d;
  logic [FIELD_W-1:0] src_port_q, src_port_d;
  logic [FIELD_W-1:0] word_len_q, word_len_d;
  logic               hdr_seen_q, hdr_seen_d;
  logic               len_err_q,  len_err_d;
  logic               hdr_err_q,  hdr_err_d;
  logic               in_rdy_q,   in_rdy_d;

  // Combinational decode.
  logic [CTRL_MAX_W-1:0] ctrl_ext_s;
  word_kind_e            kind_s;
  logic                  accept_s;
  logic                  drop_s;
  logic                  is_ioq_s;
  logic                  push_s;
  logic                  pop_s;
  logic [FIELD_W-1:0]    final_words_s;
  logic [FIELD_W-1:0]    final_bytes_s;
  logic [2:0]            next_cnt_s;
  logic [1:0]            buf_cnt_s;
  logic [BUF_W-1:0]      buf_head_s;

  // Classify the incoming word and decide whether it enters the buffer.
  always_comb begin
    ctrl_ext_s                 = '0;
    ctrl_ext_s[CTRL_WIDTH-1:0] = in_ctrl;
    kind_s        = classify_word(ctrl_ext_s);
    accept_s      = in_wr && in_rdy_q;
    // Only headers that lead the packet are stripped; later ones are payload.
    drop_s        = (state_q == ST_HDR) && (kind_s == WK_HDR);
    is_ioq_s      = drop_s && (in_ctrl == STAGE_CTRL);
    push_s        = accept_s && !drop_s;
    pop_s         = out_rdy && (buf_cnt_s != 2'd0);
    final_words_s = sat_add16(wcnt_q, 16'd1);
    final_bytes_s = sat_add16(bcnt_q, last_word_bytes(ctrl_ext_s, CTRL_WIDTH));
    next_cnt_s    = {1'b0, buf_cnt_s} + {2'b00, push_s} - {2'b00, pop_s};
  end

  // Next-state logic for the parser, counters, checks and ready.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    bcnt_d     = bcnt_q;
    byte_len_d = byte_len_q;
    src_port_d = src_port_q;
    word_len_d = word_len_q;
    hdr_seen_d = hdr_seen_q;
    len_err_d  = 1'b0;
    hdr_err_d  = 1'b0;
    in_rdy_d   = (next_cnt_s <= 3'd1);

    if (accept_s) begin
      if (kind_s == WK_EOP) begin
        // Packet complete: evaluate checks, then rearm for the next header.
        len_err_d  = hdr_seen_q &&
                     ((final_words_s != word_len_q) || (final_bytes_s != byte_len_q));
        hdr_err_d  = !hdr_seen_q || (src_port_q != PORT_EXP);
        wcnt_d     = '0;
        bcnt_d     = '0;
        hdr_seen_d = 1'b0;
        state_d    = ST_HDR;
      end else if (drop_s) begin
        if (is_ioq_s) begin
          byte_len_d = in_data[BYTE_LEN_LSB +: FIELD_W];
          src_port_d = in_data[SRC_PORT_LSB +: FIELD_W];
          word_len_d = in_data[WORD_LEN_LSB +: FIELD_W];
          hdr_seen_d = 1'b1;
        end else begin
          hdr_seen_d = hdr_seen_q;
        end
      end else begin
        // Data word, or a header-looking word inside the payload.
        wcnt_d  = sat_add16(wcnt_q, 16'd1);
        bcnt_d  = sat_add16(bcnt_q, LANE_BYTES);
        state_d = ST_DATA;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Parser registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HDR;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      byte_len_q <= '0;
      src_port_q <= '0;
      word_len_q <= '0;
      hdr_seen_q <= 1'b0;
      len_err_q  <= 1'b0;
      hdr_err_q  <= 1'b0;
      in_rdy_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      byte_len_q <= byte_len_d;
      src_port_q <= src_port_d;
      word_len_q <= word_len_d;
      hdr_seen_q <= hdr_seen_d;
      len_err_q  <= len_err_d;
      hdr_err_q  <= hdr_err_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  pkt_skid_buf #(
    .W (BUF_W)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_data_i ({in_ctrl, in_data}),
    .pop_i       (pop_s),
    .head_o      (buf_head_s),
    .count_o     (buf_cnt_s)
  );

  assign in_rdy   = in_rdy_q;
  assign out_wr   = pop_s;
  assign out_data = buf_head_s[DATA_WIDTH-1:0];
  assign out_ctrl = buf_head_s[DATA_WIDTH +: CTRL_WIDTH];
  assign len_err  = len_err_q;
  assign hdr_err  = hdr_err_q;

`ifdef RM_HDR_CHK_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] err_cnt_q;

  // Saturating counts of forwarded EOPs and of packets that raised an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_q <= 32'd0;
      err_cnt_q <= 32'd0;
    end else begin
      if (accept_s && (kind_s == WK_EOP)) begin
        pkt_cnt_q <= sat_inc32(pkt_cnt_q);
      end
      if (len_err_q || hdr_err_q) begin
        err_cnt_q <= sat_inc32(err_cnt_q);
      end
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  // Statistics disabled: no counter state is built.
`endif

endmodule

// File: tb/tb_rm_hdr_chk.sv
`timescale 1ns/1ps
module tb_rm_hdr_chk;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } word_t;

  typedef struct {
    int unsigned cyc;
    bit          e_len;
    bit          e_hdr;
  } err_rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic [7:0]  in_ctrl = 8'd0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        len_err;
  logic        hdr_err;

  rm_hdr_chk dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .in_wr    (in_wr),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .out_wr   (out_wr),
    .out_rdy  (out_rdy),
    .len_err  (len_err),
    .hdr_err  (hdr_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  word_t    exp_q[$];
  err_rec_t err_q[$];
  word_t    pkt[$];
  int       occ = 0;
  bit       chk_rdy = 1'b0;
  bit       drv_push = 1'b0;
  bit       toggle_en = 1'b0;
  int       n_chk = 0;
  int       n_fail = 0;
  int       out_cnt = 0;
  int       len_pulses = 0;
  int       hdr_pulses = 0;
  int       rdy_low = 0;
  logic [7:0] last_ctrl = 8'd0;
  int       tag = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte count of an EOP word, straight from the lane table.
  function automatic int last_bytes(input logic [7:0] c);
    case (c)
      8'h01: return 8;
      8'h02: return 7;
      8'h04: return 6;
      8'h08: return 5;
      8'h10: return 4;
      8'h20: return 3;
      8'h40: return 2;
      8'h80: return 1;
      default: return 0;
    endcase
  endfunction

  // Whole-packet model: which words survive and which errors the EOP raises.
  function automatic void model_pkt(input word_t p[$], output int ff, output bit el, output bit eh);
    bit seen = 0;
    int wl = 0, bl = 0, port = 0, nw, nb;
    ff = 0;
    while (ff < p.size() && $countones(p[ff].ctrl) >= 2) begin
      if (p[ff].ctrl == 8'hff) begin
        bl   = int'(p[ff].data[15:0]);
        port = int'(p[ff].data[31:16]);
        wl   = int'(p[ff].data[47:32]);
        seen = 1;
      end
      ff++;
    end
    nw = p.size() - ff;
    nb = 8 * (nw - 1) + last_bytes(p[p.size()-1].ctrl);
    el = seen && (nw != wl || nb != bl);
    eh = !seen || port != 0;
  endfunction

  function automatic logic [63:0] ioq(input logic [15:0] wl, input logic [15:0] port, input logic [15:0] bl);
    return {16'h0000, wl, port, bl};
  endfunction

  task automatic add_word(input logic [7:0] c);
    logic [31:0] hi;
    hi = 32'hd0d0_0000 + 32'(pkt.size());
    pkt.push_back('{c, {hi, 32'(tag)}});
  endtask

  task automatic mk_pkt(input logic [15:0] wl, input logic [15:0] port, input logic [15:0] bl,
                        input int ndata, input logic [7:0] eop_c);
    tag++;
    pkt.delete();
    pkt.push_back('{8'hff, ioq(wl, port, bl)});
    for (int i = 0; i < ndata; i++) add_word(8'h00);
    add_word(eop_c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) out_rdy = ~out_rdy;
  endtask

  task automatic clear_stats();
    out_cnt = 0; len_pulses = 0; hdr_pulses = 0; rdy_low = 0; last_ctrl = 8'd0;
  endtask

  // Drive the first n words of pkt; holds each word until in_rdy.
  task automatic send_pkt(input int n);
    int ff, budget;
    bit el, eh;
    model_pkt(pkt, ff, el, eh);
    for (int i = 0; i < n; i++) begin
      in_wr = 1'b1; in_ctrl = pkt[i].ctrl; in_data = pkt[i].data;
      budget = 0;
      while (!in_rdy) begin
        drv_push = 1'b0;
        tick();
        budget++;
        if (budget > 100) begin
          n_chk++; n_fail++;
          $display("FAIL in_rdy_timeout: got in_rdy=0 for 100 cycles, expected 1");
          in_wr = 1'b0;
          return;
        end
      end
      drv_push = (i >= ff);
      if (i >= ff) exp_q.push_back(pkt[i]);
      if (i == pkt.size() - 1) err_q.push_back('{cyc + 1, el, eh});
      tick();
    end
    in_wr = 1'b0;
    drv_push = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && budget < 200) begin
      tick();
      budget++;
    end
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d words / %0d pulses pending, expected 0", exp_q.size(), err_q.size());
      exp_q.delete(); err_q.delete();
    end
    tick(); tick();
  endtask

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin : cmp
    bit el, eh;
    word_t w;
    if (!reset) begin
      el = 1'b0; eh = 1'b0;
      if (err_q.size() > 0 && err_q[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL err_pulse_missed: got no pulse at cycle %0d, expected one", err_q[0].cyc);
        void'(err_q.pop_front());
      end
      if (err_q.size() > 0 && err_q[0].cyc == cyc) begin
        el = err_q[0].e_len; eh = err_q[0].e_hdr;
        void'(err_q.pop_front());
      end
      check("len_err", len_err, el);
      check("hdr_err", hdr_err, eh);
      if (len_err) len_pulses++;
      if (hdr_err) hdr_pulses++;
      if (chk_rdy) check("in_rdy", in_rdy, occ <= 1);
      if (!in_rdy) rdy_low++;
      check("out_wr", out_wr, out_rdy && (occ != 0));
      if (out_wr) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out_extra: got word %0h/%0h, expected none", out_ctrl, out_data);
        end else begin
          w = exp_q.pop_front();
          check("out_data", out_data, w.data);
          check("out_ctrl", out_ctrl, w.ctrl);
          out_cnt++;
          last_ctrl = out_ctrl;
        end
      end
      occ = occ + int'(drv_push) - int'(out_wr);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ff;
    bit el, eh;

    #2 reset = 1'b1;
    tick(); tick();
    check("rst_out_wr", out_wr, 0);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_len_err", len_err, 0);
    check("rst_hdr_err", hdr_err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    reset = 1'b0;
    tick();
    chk_rdy = 1'b1;

    // 60-byte packet, consistent header
    mk_pkt(16'd8, 16'd0, 16'd60, 7, 8'h10);
    model_pkt(pkt, ff, el, eh);
    check("model_p1_ff", ff, 1);
    check("model_p1_len", el, 0);
    check("model_p1_hdr", eh, 0);
    clear_stats();
    send_pkt(pkt.size());
    drain();
    check("p1_words", out_cnt, 8);
    check("p1_last_ctrl", last_ctrl, 8'h10);
    check("p1_len_pulses", len_pulses, 0);
    check("p1_hdr_pulses", hdr_pulses, 0);

    // byte_len off by one, immediately followed by a header-less EOP
    clear_stats();
    mk_pkt(16'd8, 16'd0, 16'd61, 7, 8'h10);
    model_pkt(pkt, ff, el, eh);
    check("model_p2_len", el, 1);
    check("model_p2_hdr", eh, 0);
    send_pkt(pkt.size());
    tag++;
    pkt.delete();
    add_word(8'h80);
    model_pkt(pkt, ff, el, eh);
    check("model_p3_ff", ff, 0);
    check("model_p3_len", el, 0);
    check("model_p3_hdr", eh, 1);
    send_pkt(pkt.size());
    drain();
    check("p23_words", out_cnt, 9);
    check("p23_last_ctrl", last_ctrl, 8'h80);
    check("p23_len_pulses", len_pulses, 1);
    check("p23_hdr_pulses", hdr_pulses, 1);

    // two module headers, wrong source port
    clear_stats();
    tag++;
    pkt.delete();
    pkt.push_back('{8'hff, ioq(16'd3, 16'd3, 16'd24)});
    add_word(8'hfe);
    add_word(8'h00);
    add_word(8'h00);
    add_word(8'h01);
    model_pkt(pkt, ff, el, eh);
    check("model_p4_ff", ff, 2);
    check("model_p4_hdr", eh, 1);
    send_pkt(pkt.size());
    drain();
    check("p4_words", out_cnt, 3);
    check("p4_len_pulses", len_pulses, 0);
    check("p4_hdr_pulses", hdr_pulses, 1);

    // header-looking word inside the payload is forwarded and counted
    clear_stats();
    tag++;
    pkt.delete();
    pkt.push_back('{8'hff, ioq(16'd3, 16'd0, 16'd17)});
    add_word(8'h00);
    add_word(8'h03);
    add_word(8'h80);
    send_pkt(pkt.size());
    drain();
    check("p5_words", out_cnt, 3);
    check("p5_len_pulses", len_pulses, 0);
    check("p5_hdr_pulses", hdr_pulses, 0);

    // 16-word packet with out_rdy toggling every cycle
    clear_stats();
    mk_pkt(16'd16, 16'd0, 16'd128, 15, 8'h01);
    toggle_en = 1'b1;
    send_pkt(pkt.size());
    drain();
    toggle_en = 1'b0;
    out_rdy = 1'b1;
    tick();
    check("p6_words", out_cnt, 16);
    check("p6_in_rdy_dropped", rdy_low != 0, 1);
    check("p6_len_pulses", len_pulses, 0);
    check("p6_hdr_pulses", hdr_pulses, 0);

    // reset during word 4 of 8, then a clean packet
    clear_stats();
    mk_pkt(16'd8, 16'd0, 16'd60, 7, 8'h10);
    send_pkt(4);
    reset = 1'b1;
    in_wr = 1'b0;
    drv_push = 1'b0;
    chk_rdy = 1'b0;
    #1;
    check("mid_rst_out_wr", out_wr, 0);
    check("mid_rst_in_rdy", in_rdy, 0);
    check("mid_rst_len_err", len_err, 0);
    check("mid_rst_hdr_err", hdr_err, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_ctrl", out_ctrl, 0);
    exp_q.delete();
    err_q.delete();
    occ = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_rdy = 1'b1;
    mk_pkt(16'd8, 16'd0, 16'd60, 7, 8'h10);
    send_pkt(pkt.size());
    drain();
    check("p7_len_pulses", len_pulses, 0);
    check("p7_hdr_pulses", hdr_pulses, 0);
    check("p7_last_ctrl", last_ctrl, 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
